// File: rtl/pwm_generator.sv
// PWM generator fed by the SPI register block's 8-bit duty register.
//
// A prescaler divides clk_i by CLK_DIV to produce a count tick; an 8-bit period counter
// advances on every tick, so one PWM period is 256 * CLK_DIV clocks. The duty value is
// captured into a shadow register only at the period boundary, which keeps every period
// glitch-free regardless of when pwm_val_i changes.
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   pwm_val_i       duty value; may change on any cycle, sampled only at period boundaries
//   out_en_i        per-channel enable; 0 forces the channel low
//   pwm_en_i        per-channel mode; 1 selects PWM, 0 selects static high
//   pwm_out_o       registered channel outputs, all channels in phase
//   period_start_o  one-clock pulse at the start of each PWM period
module pwm_generator #(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned NUM_CH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        pwm_val_i,
  input  logic [NUM_CH-1:0] out_en_i,
  input  logic [NUM_CH-1:0] pwm_en_i,
  output logic [NUM_CH-1:0] pwm_out_o,
  output logic              period_start_o
);

  localparam int unsigned PsW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(CLK_DIV - 1);

  logic [PsW-1:0]    ps_q, ps_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        duty_q, duty_d;
  logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
  logic              period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic wave;

  // With CLK_DIV = 1 PsLast is 0, so the prescaler holds at 0 and ticks every cycle.
  assign tick     = (ps_q == PsLast);
  assign boundary = tick && (cnt_q == 8'hFF);

  always_comb begin
    ps_d           = tick ? '0 : ps_q + PsW'(1);
    cnt_d          = tick ? cnt_q + 8'd1 : cnt_q;
    duty_d         = boundary ? pwm_val_i : duty_q;
    period_start_d = boundary;
  end

  // The compare looks at the counter state being entered so that the registered output
  // lines up with it: the first high clock of a period is the period_start_o clock.
  assign wave = (cnt_d < duty_d);

  always_comb begin
    pwm_out_d = out_en_i & (~pwm_en_i | {NUM_CH{wave}});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q           <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      ps_q           <= ps_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out_o      = pwm_out_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: four instances with different CLK_DIV/NUM_CH
// share clock, reset and duty input. A reference model derives every output from the
// number of clocks elapsed since reset release.
module tb_pwm_generator;

  localparam int DA = 13;
  localparam int DB = 1;
  localparam int DC = 2;
  localparam int DD = 65535;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pwm_val = 8'h80;
  logic [7:0] oe8 = 8'hFF;
  logic [7:0] pe8 = 8'hFF;
  logic [3:0] oe_b = 4'hF;
  logic [3:0] pe_b = 4'hF;

  logic [7:0] pwm_out_a, pwm_out_c;
  logic [3:0] pwm_out_b;
  logic [0:0] pwm_out_d;
  logic       ps_a, ps_b, ps_c, ps_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwm_generator #(.CLK_DIV(DA), .NUM_CH(8)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .pwm_val_i(pwm_val), .out_en_i(oe8), .pwm_en_i(pe8),
    .pwm_out_o(pwm_out_a), .period_start_o(ps_a)
  );
  pwm_generator #(.CLK_DIV(DB), .NUM_CH(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .pwm_val_i(pwm_val), .out_en_i(oe_b), .pwm_en_i(pe_b),
    .pwm_out_o(pwm_out_b), .period_start_o(ps_b)
  );
  pwm_generator #(.CLK_DIV(DC), .NUM_CH(8)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .pwm_val_i(pwm_val), .out_en_i(oe8), .pwm_en_i(pe8),
    .pwm_out_o(pwm_out_c), .period_start_o(ps_c)
  );
  pwm_generator #(.CLK_DIV(DD), .NUM_CH(1)) u_dut_d (
    .clk_i(clk), .rst_ni(rst_n), .pwm_val_i(pwm_val), .out_en_i(oe8[0:0]),
    .pwm_en_i(pe8[0:0]), .pwm_out_o(pwm_out_d), .period_start_o(ps_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // n = clock edges since reset release. Period k covers n in [k*256*d, (k+1)*256*d);
  // its duty is the pwm_val present just before edge k*256*d (0 for the first period).
  function automatic logic [7:0] next_duty(input int n, input int d, input logic [7:0] duty,
                                           input logic [7:0] val);
    return ((n % (256 * d)) == 0) ? val : duty;
  endfunction

  function automatic logic [7:0] model_out(input int n, input int d, input logic [7:0] duty,
                                           input logic [7:0] oe, input logic [7:0] pe);
    logic wave;
    wave = ((n % (256 * d)) / d) < int'(duty);
    return oe & (~pe | {8{wave}});
  endfunction

  int         n_a, n_b, n_c, n_d;
  logic [7:0] duty_a, duty_b, duty_c, duty_d;
  logic [7:0] exp_a, exp_b, exp_c, exp_d;
  logic       eps_a, eps_b, eps_c, eps_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_a <= 0; n_b <= 0; n_c <= 0; n_d <= 0;
      duty_a <= '0; duty_b <= '0; duty_c <= '0; duty_d <= '0;
      exp_a <= '0; exp_b <= '0; exp_c <= '0; exp_d <= '0;
      eps_a <= 1'b0; eps_b <= 1'b0; eps_c <= 1'b0; eps_d <= 1'b0;
    end else begin
      n_a    <= n_a + 1;
      duty_a <= next_duty(n_a + 1, DA, duty_a, pwm_val);
      exp_a  <= model_out(n_a + 1, DA, next_duty(n_a + 1, DA, duty_a, pwm_val), oe8, pe8);
      eps_a  <= ((n_a + 1) % (256 * DA)) == 0;
      n_b    <= n_b + 1;
      duty_b <= next_duty(n_b + 1, DB, duty_b, pwm_val);
      exp_b  <= model_out(n_b + 1, DB, next_duty(n_b + 1, DB, duty_b, pwm_val),
                          {4'b0, oe_b}, {4'b0, pe_b});
      eps_b  <= ((n_b + 1) % (256 * DB)) == 0;
      n_c    <= n_c + 1;
      duty_c <= next_duty(n_c + 1, DC, duty_c, pwm_val);
      exp_c  <= model_out(n_c + 1, DC, next_duty(n_c + 1, DC, duty_c, pwm_val), oe8, pe8);
      eps_c  <= ((n_c + 1) % (256 * DC)) == 0;
      n_d    <= n_d + 1;
      duty_d <= next_duty(n_d + 1, DD, duty_d, pwm_val);
      exp_d  <= model_out(n_d + 1, DD, next_duty(n_d + 1, DD, duty_d, pwm_val),
                          {7'b0, oe8[0]}, {7'b0, pe8[0]});
      eps_d  <= ((n_d + 1) % (256 * DD)) == 0;
    end
  end

  // Per-cycle comparison plus an independent period-interval measurement.
  int since_a = 0, since_b = 0, since_c = 0;

  always begin
    @(posedge clk);
    #3;
    chk("a_out", 32'(pwm_out_a), 32'(exp_a));
    chk("b_out", 32'(pwm_out_b), 32'(exp_b[3:0]));
    chk("c_out", 32'(pwm_out_c), 32'(exp_c));
    chk("d_out", 32'(pwm_out_d), 32'(exp_d[0]));
    chk("a_ps", 32'(ps_a), 32'(eps_a));
    chk("b_ps", 32'(ps_b), 32'(eps_b));
    chk("c_ps", 32'(ps_c), 32'(eps_c));
    chk("d_ps", 32'(ps_d), 32'(eps_d));
    if (!rst_n) begin
      since_a = 0; since_b = 0; since_c = 0;
    end else begin
      since_a++; since_b++; since_c++;
      if (ps_a) begin chk("a_period", since_a, 256 * DA); since_a = 0; end
      if (ps_b) begin chk("b_period", since_b, 256 * DB); since_b = 0; end
      if (ps_c) begin chk("c_period", since_c, 256 * DC); since_c = 0; end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ps_a(input int limit);
    int i;
    i = 0;
    do begin
      @(posedge clk); #3; i++;
    end while (!ps_a && i < limit);
    chk("wait_ps_a", 32'(ps_a), 32'd1);
  endtask

  // Waits for a period_start on instance b, then counts pwm_out_b[1] high clocks over the
  // 256-clock period. At step wr_step (0 = pulse clock) pwm_val is rewritten to wr_val.
  task automatic measure_b(input logic [7:0] wr_val, input int wr_step, output int hi,
                           output logic first);
    int i;
    i = 0;
    do begin
      @(posedge clk); #3; i++;
    end while (!ps_b && i < 600);
    chk("wait_ps_b", 32'(ps_b), 32'd1);
    first = pwm_out_b[1];
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) begin
        @(posedge clk); #3;
      end
      hi += int'(pwm_out_b[1]);
      if (k == wr_step) begin
        @(negedge clk);
        pwm_val = wr_val;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi;
    logic first;

    // Reset and first period at CLK_DIV = 13, duty 0x80 held.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_a", 32'(pwm_out_a), 32'd0);
    chk("rst_ps_a", 32'(ps_a), 32'd0);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 3400; i++) begin
      @(posedge clk); #3;
      if (ps_a) break;
      hi += int'(pwm_out_a[0]);
    end
    chk("first_period_low", hi, 0);
    chk("first_ps_a", 32'(ps_a), 32'd1);
    hi = 0;
    for (int k = 0; k < 256 * DA; k++) begin
      if (k > 0) begin
        @(posedge clk); #3;
      end
      hi += int'(pwm_out_a[0]);
    end
    chk("a_high_0x80", hi, 128 * DA);

    // Duty extremes at CLK_DIV = 1.
    @(negedge clk); pwm_val = 8'h00;
    measure_b(8'h00, -1, hi, first);
    chk("b_high_0x00", hi, 0);
    @(negedge clk); pwm_val = 8'hFF;
    measure_b(8'hFF, -1, hi, first);
    chk("b_high_0xff", hi, 255);
    @(negedge clk); pwm_val = 8'h01;
    measure_b(8'h01, -1, hi, first);
    chk("b_high_0x01", hi, 1);
    chk("b_0x01_at_ps", 32'(first), 32'd1);

    // Deferred update: mid-period write waits, boundary-cycle write applies next period.
    @(negedge clk); pwm_val = 8'h40;
    measure_b(8'hC0, 100, hi, first);
    chk("b_defer_cur", hi, 64);
    measure_b(8'h20, 255, hi, first);
    chk("b_defer_next", hi, 192);
    measure_b(8'h20, -1, hi, first);
    chk("b_bnd_write", hi, 32);

    // Enable matrix on the 4-channel instance.
    @(negedge clk);
    oe_b = 4'b1010; pe_b = 4'b0110; pwm_val = 8'h80;
    measure_b(8'h80, 9, hi, first);
    @(posedge clk); #3;
    chk("en_ch0", 32'(pwm_out_b[0]), 32'd0);
    chk("en_ch1", 32'(pwm_out_b[1]), 32'd1);
    chk("en_ch2", 32'(pwm_out_b[2]), 32'd0);
    chk("en_ch3", 32'(pwm_out_b[3]), 32'd1);
    @(negedge clk); oe_b[1] = 1'b0;
    @(posedge clk); #3;
    chk("en_ch1_off", 32'(pwm_out_b[1]), 32'd0);
    @(negedge clk); oe_b[1] = 1'b1;
    @(posedge clk); #3;
    chk("en_ch1_on", 32'(pwm_out_b[1]), 32'd1);

    // Randomized duty writes and enable changes, checked every cycle by the model.
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) pwm_val = 8'($urandom);
      if ($urandom_range(199) == 0) begin
        oe8  = 8'($urandom);
        pe8  = 8'($urandom);
        oe_b = 4'($urandom);
        pe_b = 4'($urandom);
      end
    end

    // Reset mid-period at cnt = 150, duty 0x80, channel 7 static high.
    @(negedge clk);
    pwm_val = 8'h80; oe8 = 8'hFF; pe8 = 8'h7F;
    wait_ps_a(3400);
    repeat (150 * DA + 6) @(negedge clk);
    chk("pre_rst_ch7", 32'(pwm_out_a[7]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'(pwm_out_a), 32'd0);
    chk("async_rst_b", 32'(pwm_out_b), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 3400; i++) begin
      @(posedge clk); #3;
      if (ps_a) break;
      hi += int'(pwm_out_a[0]);
    end
    chk("rerun_first_low", hi, 0);
    chk("rerun_ps_a", 32'(ps_a), 32'd1);
    repeat (20) @(posedge clk);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
